// File: rtl/marco_pkg.sv
// Shared definitions for the alarm comparator: FSM state encodings and the
// default time-field width.
package marco_pkg;

  localparam int unsigned DEF_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RING = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/comp_n_b.sv
// Gated N-bit equality comparator: c = en AND (a == b).
module comp_n_b
  import marco_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  output logic             c
);

  assign c = en & (a == b);

endmodule

// File: rtl/alarm_match.sv
// Alarm-clock matcher: masked per-field compare of the current time against a
// loadable alarm register, with a ring/hold FSM and a sticky missed flag.
module alarm_match
  import marco_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned NFIELD   = 3,
  parameter int unsigned RING_CYC = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [NFIELD*WIDTH-1:0] load_data,
  input  logic [NFIELD*WIDTH-1:0] cur,
  input  logic [NFIELD-1:0]       mask,
  input  logic                    ack,
  output logic                    match,
  output logic                    alarm_pulse,
  output logic                    ring,
  output logic                    missed
);

  localparam int unsigned CW = $clog2(RING_CYC) + 1;
  localparam int unsigned TW = NFIELD * WIDTH;

  logic [TW-1:0]     alm;
  logic [NFIELD-1:0] eq_raw;
  logic [NFIELD-1:0] eq;
  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              missed_nxt;
  logic              timeout;

  for (genvar gi = 0; gi < NFIELD; gi++) begin : g_cmp
    comp_n_b #(.WIDTH(WIDTH)) u_cmp (
      .a  (cur[gi*WIDTH +: WIDTH]),
      .b  (alm[gi*WIDTH +: WIDTH]),
      .en (1'b1),
      .c  (eq_raw[gi])
    );
  end

  assign eq = eq_raw | mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    alm <= '0;
    else if (load) alm <= load_data;
  end

  // The compare on a load edge uses the outgoing alarm value, so it is
  // discarded; a new alarm matches with the normal one-cycle latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    match <= 1'b0;
    else if (load) match <= 1'b0;
    else           match <= en & (&eq) & ~(&mask);
  end

  assign timeout = (cnt == CW'(RING_CYC - 1));

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    missed_nxt = missed;
    if (load || ack) missed_nxt = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
    end else if (load) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (match) begin
            state_nxt = RING;
            cnt_nxt   = '0;
          end
        end
        RING: begin
          cnt_nxt = cnt + CW'(1);
          if (ack) begin
            state_nxt = HOLD;
          end else if (timeout) begin
            state_nxt  = HOLD;
            missed_nxt = 1'b1;
          end
        end
        HOLD: begin
          if (!match) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      missed <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      missed <= missed_nxt;
    end
  end

  assign ring        = (state == RING);
  assign alarm_pulse = (state == RING) && (cnt == '0);

endmodule

// File: doc/alarm_match.md
ALARM_MATCH -- requirements
Module: alarm_match

Interface
REQ-001 Parameter WIDTH, default 6, bit width of one time field.
REQ-002 Parameter NFIELD, default 3, number of fields (field 0 = seconds, 1 = minutes, 2 = hours).
REQ-003 Parameter RING_CYC, default 8, maximum ring duration in clock cycles; RING_CYC SHALL be at least 1.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 en  in  1  global enable; 0 disables matching and ringing.
REQ-007 load  in  1  write strobe for the alarm register.
REQ-008 load_data  in  NFIELD*WIDTH  new alarm value; field i occupies bits [i*WIDTH +: WIDTH].
REQ-009 cur  in  NFIELD*WIDTH  current time, packed the same way as load_data.
REQ-010 mask  in  NFIELD  1 = ignore field i in the compare.
REQ-011 ack  in  1  user acknowledge; stops ringing.
REQ-012 match  out  1  registered equality result.
REQ-013 alarm_pulse  out  1  one-cycle pulse on entry to RING.
REQ-014 ring  out  1  high while in RING.
REQ-015 missed  out  1  sticky flag; the last ring ended by timeout.

Function
REQ-016 Alarm register alm SHALL capture load_data on the clock edge where load=1.
REQ-017 Per-field equality SHALL be eq_i = (cur field i == alm field i) OR mask[i].
REQ-018 match SHALL update every cycle to en AND (all eq_i) AND NOT (all mask bits set), giving 1-cycle latency from cur/alm/mask/en.
REQ-019 With every mask bit set, match SHALL stay 0; the alarm is disabled.
REQ-020 FSM states: IDLE, RING, HOLD.
REQ-021 IDLE->RING SHALL occur when match=1 and en=1.
REQ-022 The ring counter SHALL clear on entry to RING.
REQ-023 alarm_pulse SHALL be 1 only in the first RING cycle.
REQ-024 In RING, ring=1 and the counter SHALL increment each cycle.
REQ-025 RING->HOLD SHALL occur on ack=1 or when the counter reaches RING_CYC-1, so RING lasts at most RING_CYC cycles.
REQ-026 If ack and timeout occur in the same cycle, ack SHALL take priority, leaving missed=0.
REQ-027 HOLD->IDLE SHALL occur only when match=0; a persistent match SHALL ring at most once.
REQ-028 missed SHALL set on a timeout exit from RING and clear on ack=1 or load=1.
REQ-029 en=0 in any state SHALL force IDLE on the next edge, with ring=0 and alarm_pulse=0 in that cycle.
REQ-030 load=1 in any state SHALL force IDLE on the next edge; if the new value matches, RING SHALL follow under the normal match latency.
REQ-031 Precedence SHALL be: en=0, then load, then ack, then timeout.
REQ-032 ack outside RING SHALL have no effect except clearing missed.
REQ-033 Latency: cur matches at edge k -> match=1 after edge k+1 -> ring=1 and alarm_pulse=1 after edge k+2.

Reset
REQ-034 rst_n=0 SHALL immediately clear alm, match, the ring counter, missed, ring and alarm_pulse, and set the state to IDLE.
REQ-035 Reset asserted mid-RING SHALL drop ring within the same cycle without waiting for a clock edge.
REQ-036 After rst_n deasserts, the block SHALL resume operation on the next rising edge.

Structure
REQ-037 Shared package marco_pkg SHALL hold the FSM state encodings (IDLE=2'd0, RING=2'd1, HOLD=2'd2) and the default WIDTH.
REQ-038 Equality SHALL use a sub-module comp_n_b (parameter WIDTH; ports a, b, en, c = en AND (a==b)), instantiated NFIELD times.
REQ-039 The ring counter width SHALL be $clog2(RING_CYC)+1.

Verification (WIDTH=6, NFIELD=3, RING_CYC=8)
REQ-040 Load {h=7,m=30,s=0}, mask=0, en=1, step cur to {7,30,0} -> match=1 one cycle later, ring=1 and alarm_pulse=1 the cycle after, alarm_pulse=0 on the following cycle.
REQ-041 Ring with no ack and cur held -> ring high exactly 8 cycles, then missed=1, state HOLD, no retrigger; change cur to {7,30,1} -> IDLE.
REQ-042 ack in the 3rd RING cycle -> ring=0 the next cycle, missed stays 0; ack coincident with the 8th cycle -> missed=0.
REQ-043 mask=3'b001, alm {7,30,0}, cur {7,30,45} -> match=1; mask=3'b111 -> match stays 0 for any cur.
REQ-044 rst_n pulled low mid-RING between edges -> ring=0 immediately, alm=0; en=0 mid-RING -> ring=0 after the next edge.
REQ-045 load of the current cur value during HOLD -> IDLE, then RING two edges later with alarm_pulse=1.
